// File: rtl/mem_access_unit.sv
// Memory access unit: owns MAR/MDR and runs read/write
// transactions toward memory with wait states and timeout.
module mem_access_unit #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] z,
  input  logic              ld_mar,
  input  logic              ld_mdr_z,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic              auto_inc,
  input  logic              t_mdr_x,
  output logic [DATA_W-1:0] x_data,
  output logic              x_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              inc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;

  // Transaction FSM, register loads and status pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      inc   <= 1'b0;
      mar   <= '0;
      mdr   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ld_mar)
            mar <= z[ADDR_W-1:0];
          if (ld_mdr_z)
            mdr <= z;
          if (rd_req) begin
            state <= RD;
            cnt   <= '0;
            inc   <= auto_inc;
            err   <= wr_req;
          end else if (wr_req) begin
            state <= WR;
            cnt   <= '0;
            inc   <= auto_inc;
          end
        end
        RD, WR: begin
          if (mem_ready) begin
            if (state == RD)
              mdr <= mem_data_out;
            if (inc)
              mar <= mar + ADDR_W'(1);
            state <= IDLE;
            done  <= 1'b1;
          end else if (cnt == LAST) begin
            state <= IDLE;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode from registered state only
  always_comb begin
    mem_rd = (state == RD);
    mem_wr = (state == WR);
    busy   = (state != IDLE);
  end

  // Bus views of MAR/MDR
  always_comb begin
    x_data      = mdr;
    x_oe        = t_mdr_x;
    mem_addr    = mar;
    mem_data_in = mdr;
  end

endmodule
